// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive engine.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_ADDR,
        REG_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic [3:0] DEV_ADDR_HI_DEF = 4'b1010;
    localparam logic       I2C_ACK         = 1'b0;
    localparam logic       I2C_NACK        = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Pin, strap and strobe bundle between the I2C slave engine and its register file / serializer.
interface i2c_slave_rx_if #(
    parameter int ADDR_W = 11
);
    logic              i2c_sda_raw;
    logic              i2c_scl_raw;
    logic [2:0]        i2c_addr_bits;
    logic              i2c_rw;
    logic [ADDR_W-1:0] i2c_addr;
    logic              addr_valid;
    logic              ack_drive;
    logic [7:0]        wr_data;
    logic              wr_valid;
    logic              rd_req;
    logic              start_out;
    logic              stop_out;
    logic              busy;

    modport slave (
        input  i2c_sda_raw, i2c_scl_raw, i2c_addr_bits,
        output i2c_rw, i2c_addr, addr_valid, ack_drive, wr_data, wr_valid,
               rd_req, start_out, stop_out, busy
    );

    modport master (
        output i2c_sda_raw, i2c_scl_raw, i2c_addr_bits,
        input  i2c_rw, i2c_addr, addr_valid, ack_drive, wr_data, wr_valid,
               rd_req, start_out, stop_out, busy
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Multi-flop synchroniser for one open-drain I2C line with edge pulses taken from the last two stages.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};

    // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) sync_q <= '1;
        else        sync_q <= sync_d;
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = ~sync_q[SYNC_STAGES-1] &  sync_q[SYNC_STAGES-2];
    assign fall  =  sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];
endmodule

// File: rtl/i2c_slave_rx.sv
// I2C slave receive/control engine: START/STOP detection, device/register address decode, write and read strobes.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter int         SYNC_STAGES = 3,
    parameter logic [3:0] DEV_ADDR_HI = DEV_ADDR_HI_DEF,
    parameter int         ADDR_BYTES  = 2,
    parameter int         ADDR_W      = 11
) (
    input  logic           Clock,
    input  logic           Reset,
    i2c_slave_rx_if.slave  bus
);
    localparam int         ASR_W   = 8 * ADDR_BYTES;
    localparam logic [2:0] BC_LAST = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] BC_ALL  = 3'(ADDR_BYTES);

    logic sda, sda_rise, sda_fall, scl, scl_rise, scl_fall;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .Clock(Clock), .Reset(Reset), .din(bus.i2c_sda_raw),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );
    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .Clock(Clock), .Reset(Reset), .din(bus.i2c_scl_raw),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_state_t        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
    logic [7:0]        shift_q, shift_d, wr_data_q, wr_data_d;
    logic [ASR_W-1:0]  addr_sr_q, addr_sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d, ack_q, ack_d, mack_q, mack_d;
    logic              rw_q, rw_d, busy_q, busy_d, wr_valid_q, wr_valid_d;
    logic              rd_req_q, rd_req_d, start_q, start_d, stop_q, stop_d;
    logic              start_det, stop_det, byte_done;
    logic [7:0]        byte_new;

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign byte_new  = {shift_q[6:0], sda};
    assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            wr_data_q    <= '0;
            addr_sr_q    <= '0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            mack_q       <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            wr_data_q    <= wr_data_d;
            addr_sr_q    <= addr_sr_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            ack_q        <= ack_d;
            mack_q       <= mack_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            wr_valid_q   <= wr_valid_d;
            rd_req_q     <= rd_req_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        wr_data_d    = wr_data_q;
        addr_sr_d    = addr_sr_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        ack_d        = ack_q;
        mack_d       = mack_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        wr_valid_d   = 1'b0;
        rd_req_d     = 1'b0;
        start_d      = 1'b0;
        stop_d       = 1'b0;

        // START/STOP pre-empt everything, including a coincident SCL rise.
        if (start_det) begin
            state_d    = DEV_ADDR;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            ack_d      = 1'b0;
            mack_d     = 1'b0;
            start_d    = 1'b1;
            busy_d     = 1'b1;
        end else if (stop_det) begin
            state_d      = IDLE;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            ack_d        = 1'b0;
            mack_d       = 1'b0;
            addr_valid_d = 1'b0;
            stop_d       = 1'b1;
            busy_d       = 1'b0;
        end else begin
            if (scl_rise && (state_q inside {DEV_ADDR, REG_ADDR, WR_DATA, RD_DATA})) begin
                shift_d   = byte_new;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            unique case (state_q)
                DEV_ADDR: if (byte_done) begin
                    if (byte_new[7:1] == {DEV_ADDR_HI, bus.i2c_addr_bits}) begin
                        state_d = DEV_ACK;
                        rw_d    = byte_new[0];
                    end else begin
                        state_d = IGNORE;
                    end
                end
                REG_ADDR: if (byte_done) begin
                    addr_sr_d  = ASR_W'({addr_sr_q, byte_new});
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    state_d    = REG_ACK;
                    if (byte_cnt_q == BC_LAST) begin
                        addr_d       = addr_sr_d[ADDR_W-1:0];
                        addr_valid_d = 1'b1;
                    end
                end
                WR_DATA: if (byte_done) state_d = WR_ACK;
                RD_DATA: if (byte_done) state_d = RD_ACK;
                // First SCL fall of an ACK slot raises ack_drive, the second ends the slot.
                DEV_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
                    if (!ack_q) begin
                        ack_d = 1'b1;
                        if (state_q == WR_ACK) begin
                            wr_data_d  = shift_q;
                            wr_valid_d = 1'b1;
                        end
                    end else begin
                        ack_d = 1'b0;
                        if (state_q == DEV_ACK) begin
                            if (rw_q) begin
                                state_d  = RD_DATA;
                                rd_req_d = 1'b1;
                            end else begin
                                state_d    = REG_ADDR;
                                byte_cnt_d = '0;
                            end
                        end else if (state_q == REG_ACK) begin
                            state_d = (byte_cnt_q == BC_ALL) ? WR_DATA : REG_ADDR;
                        end else begin
                            state_d = WR_DATA;
                            addr_d  = addr_q + ADDR_W'(1);
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_NACK) state_d = IGNORE;
                        else                 mack_d  = 1'b1;
                    end else if (scl_fall && mack_q) begin
                        mack_d   = 1'b0;
                        addr_d   = addr_q + ADDR_W'(1);
                        rd_req_d = 1'b1;
                        state_d  = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.i2c_rw     = rw_q;
    assign bus.i2c_addr   = addr_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.ack_drive  = ack_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_valid   = wr_valid_q;
    assign bus.rd_req     = rd_req_q;
    assign bus.start_out  = start_q;
    assign bus.stop_out   = stop_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Scoreboard bench: two slave instances (2-byte and 1-byte register address) share one I2C bus.
module tb_i2c_slave_rx;
    localparam int Q = 100;
    localparam logic [2:0] EV_START = 3'd1, EV_STOP = 3'd2, EV_ACK = 3'd3, EV_WR = 3'd4, EV_RD = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [10:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic Clock = 1'b0;
    logic Reset;
    logic sda, scl;
    logic mon_en = 1'b0;
    logic ack_prev1 = 1'b0, ack_prev2 = 1'b0;
    int   checks = 0, errors = 0;
    ev_t  sb0[$], sb1[$];

    always #5 Clock = ~Clock;

    i2c_slave_rx_if #(.ADDR_W(11)) bus1 ();
    i2c_slave_rx_if #(.ADDR_W(8))  bus2 ();

    assign bus1.i2c_sda_raw = sda;
    assign bus1.i2c_scl_raw = scl;
    assign bus2.i2c_sda_raw = sda;
    assign bus2.i2c_scl_raw = scl;

    i2c_slave_rx #(.SYNC_STAGES(3), .DEV_ADDR_HI(4'b1010), .ADDR_BYTES(2), .ADDR_W(11)) dut1 (
        .Clock(Clock), .Reset(Reset), .bus(bus1.slave));
    i2c_slave_rx #(.SYNC_STAGES(3), .DEV_ADDR_HI(4'b1010), .ADDR_BYTES(1), .ADDR_W(8)) dut2 (
        .Clock(Clock), .Reset(Reset), .bus(bus2.slave));

    task automatic push(input int d, input logic [2:0] k, input logic [10:0] a, input logic [7:0] v);
        ev_t e;
        e = '{kind: k, addr: a, data: v};
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic observe(input int d, input logic [2:0] k, input logic [10:0] a, input logic [7:0] v);
        ev_t act, exp;
        act = '{kind: k, addr: a, data: v};
        checks++;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            errors++;
            $display("FAIL dut%0d unexpected_event: got kind=%0d addr=%h data=%h, required none", d + 1, k, a, v);
        end else begin
            exp = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            if (exp != act) begin
                errors++;
                $display("FAIL dut%0d event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         d + 1, k, a, v, exp.kind, exp.addr, exp.data);
            end
        end
    endtask

    always @(negedge Clock) begin
        if (mon_en) begin
            if (bus1.start_out)                observe(0, EV_START, '0, '0);
            if (bus1.stop_out)                 observe(0, EV_STOP, '0, '0);
            if (bus1.ack_drive && !ack_prev1)  observe(0, EV_ACK, '0, '0);
            if (bus1.wr_valid)                 observe(0, EV_WR, bus1.i2c_addr, bus1.wr_data);
            if (bus1.rd_req)                   observe(0, EV_RD, bus1.i2c_addr, '0);
            if (bus2.start_out)                observe(1, EV_START, '0, '0);
            if (bus2.stop_out)                 observe(1, EV_STOP, '0, '0);
            if (bus2.ack_drive && !ack_prev2)  observe(1, EV_ACK, '0, '0);
            if (bus2.wr_valid)                 observe(1, EV_WR, {3'b000, bus2.i2c_addr}, bus2.wr_data);
            if (bus2.rd_req)                   observe(1, EV_RD, {3'b000, bus2.i2c_addr}, '0);
        end
        ack_prev1 <= bus1.ack_drive;
        ack_prev2 <= bus2.ack_drive;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        sda = b; #Q;
        scl = 1'b1; #(2 * Q);
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(1'b1);
    endtask

    task automatic read_byte(input logic [7:0] v, input logic mack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(mack);
    endtask

    task automatic i2c_start();
        push(0, EV_START, '0, '0);
        push(1, EV_START, '0, '0);
        sda = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        push(0, EV_STOP, '0, '0);
        push(1, EV_STOP, '0, '0);
        sda = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda = 1'b1; #Q;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags1"}, {bus1.i2c_rw, bus1.addr_valid, bus1.ack_drive, bus1.wr_valid,
                               bus1.rd_req, bus1.start_out, bus1.stop_out, bus1.busy}, 0);
        chk({tag, "_addr1"}, int'(bus1.i2c_addr), 0);
        chk({tag, "_wrdata1"}, int'(bus1.wr_data), 0);
        chk({tag, "_flags2"}, {bus2.i2c_rw, bus2.addr_valid, bus2.ack_drive, bus2.busy}, 0);
    endtask

    initial begin
        Reset = 1'b0;
        sda = 1'b1;
        scl = 1'b1;
        bus1.i2c_addr_bits = 3'b000;
        bus2.i2c_addr_bits = 3'b111;
        #(Q / 2);
        chk_all_zero("reset");
        Reset = 1'b1;
        #(Q / 2);
        mon_en = 1'b1;
        #Q;

        // Write 0x5A, 0xC3 starting at register 0x123
        i2c_start();
        push(0, EV_ACK, '0, '0); send_byte(8'hA0);
        push(0, EV_ACK, '0, '0); send_byte(8'h01);
        push(0, EV_ACK, '0, '0); send_byte(8'h23);
        chk("wr_addr", int'(bus1.i2c_addr), 'h123);
        chk("wr_addr_valid", int'(bus1.addr_valid), 1);
        push(0, EV_ACK, '0, '0); push(0, EV_WR, 11'h123, 8'h5A); send_byte(8'h5A);
        push(0, EV_ACK, '0, '0); push(0, EV_WR, 11'h124, 8'hC3); send_byte(8'hC3);
        i2c_stop();
        chk("wr_stop_addr_valid", int'(bus1.addr_valid), 0);
        chk("wr_stop_busy", int'(bus1.busy), 0);
        chk("wr_stop_addr_kept", int'(bus1.i2c_addr), 'h125);
        #Q;

        // Wrong device address: straps 001 do not match 0xA0
        bus1.i2c_addr_bits = 3'b001;
        i2c_start();
        send_byte(8'hA0);
        chk("ign_busy", int'(bus1.busy), 1);
        chk("ign_ack", int'(bus1.ack_drive), 0);
        send_byte(8'h55);
        i2c_stop();
        #Q;

        // Random read from 0x7FF with wrap, final NACK
        bus1.i2c_addr_bits = 3'b000;
        i2c_start();
        push(0, EV_ACK, '0, '0); send_byte(8'hA0);
        push(0, EV_ACK, '0, '0); send_byte(8'h07);
        push(0, EV_ACK, '0, '0); send_byte(8'hFF);
        i2c_start();
        push(0, EV_ACK, '0, '0); push(0, EV_RD, 11'h7FF, '0); send_byte(8'hA1);
        chk("rd_rw", int'(bus1.i2c_rw), 1);
        push(0, EV_RD, 11'h000, '0); read_byte(8'h3C, 1'b0);
        push(0, EV_RD, 11'h001, '0); read_byte(8'hC5, 1'b0);
        read_byte(8'h81, 1'b1);
        chk("rd_nack_busy", int'(bus1.busy), 1);
        chk("rd_nack_addr", int'(bus1.i2c_addr), 'h001);
        send_bit(1'b0);
        i2c_stop();
        chk("rd_stop_busy", int'(bus1.busy), 0);
        #Q;

        // STOP after 5 bits of a data byte
        i2c_start();
        push(0, EV_ACK, '0, '0); send_byte(8'hA0);
        push(0, EV_ACK, '0, '0); send_byte(8'h00);
        push(0, EV_ACK, '0, '0); send_byte(8'h10);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        i2c_stop();
        chk("partial_addr_valid", int'(bus1.addr_valid), 0);
        chk("partial_busy", int'(bus1.busy), 0);
        chk("partial_addr", int'(bus1.i2c_addr), 'h010);
        #Q;

        // Asynchronous reset in the middle of a write byte
        i2c_start();
        push(0, EV_ACK, '0, '0); send_byte(8'hA0);
        push(0, EV_ACK, '0, '0); send_byte(8'h00);
        push(0, EV_ACK, '0, '0); send_byte(8'h20);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        sda = 1'b0; #Q;
        scl = 1'b1;
        #3 Reset = 1'b0;
        #1 chk_all_zero("async_rst");
        #(Q - 4);
        scl = 1'b0; #Q;
        sda = 1'b1;
        Reset = 1'b1; #Q;
        i2c_stop();
        chk("post_rst_busy", int'(bus1.busy), 0);
        #Q;

        // One-byte register address instance
        bus1.i2c_addr_bits = 3'b001;
        bus2.i2c_addr_bits = 3'b000;
        i2c_start();
        push(1, EV_ACK, '0, '0); send_byte(8'hA0);
        push(1, EV_ACK, '0, '0); send_byte(8'h10);
        chk("ab1_addr", int'(bus2.i2c_addr), 'h10);
        push(1, EV_ACK, '0, '0); push(1, EV_WR, 11'h010, 8'hFF); send_byte(8'hFF);
        push(1, EV_ACK, '0, '0); push(1, EV_WR, 11'h011, 8'h00); send_byte(8'h00);
        i2c_stop();
        chk("ab1_addr_kept", int'(bus2.i2c_addr), 'h12);
        #Q;

        mon_en = 1'b0;
        while (sb0.size() > 0) begin
            ev_t e;
            e = sb0.pop_front();
            checks++; errors++;
            $display("FAIL dut1 missing_event: got none, required kind=%0d addr=%h data=%h", e.kind, e.addr, e.data);
        end
        while (sb1.size() > 0) begin
            ev_t e;
            e = sb1.pop_front();
            checks++; errors++;
            $display("FAIL dut2 missing_event: got none, required kind=%0d addr=%h data=%h", e.kind, e.addr, e.data);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
